// File: rtl/switch_bounce_pkg.sv
// Shared types, constants and sizing helpers for the switch bounce generator.
package switch_bounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic int unsigned cnt_width(input int unsigned settle_cycles,
                                              input int unsigned max_interval);
        int unsigned largest;
        largest = (settle_cycles > max_interval) ? settle_cycles : max_interval;
        return 32'($clog2(largest + 1));
    endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that advances on step_i; a zero seed is replaced by 16'h0001.
// Only built when SWITCH_BOUNCE_GEN_JITTER_EN is defined, since nothing else uses it.
`ifdef SWITCH_BOUNCE_GEN_JITTER_EN
module lfsr16
    import switch_bounce_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    localparam logic [15:0] ResetVal = (Seed == 16'h0000) ? 16'h0001 : Seed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_o <= ResetVal;
        end else if (step_i) begin
            state_o <= (state_o >> 1) ^ (state_o[0] ? LfsrTaps : 16'h0000);
        end
    end

endmodule
`endif

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: accepts a level command, emits bounce glitches, holds, then ticks done.
// Define SWITCH_BOUNCE_GEN_JITTER_EN for LFSR-jittered toggle intervals; otherwise every interval is MinHold.
module switch_bounce_gen
    import switch_bounce_pkg::*;
#(
    parameter int unsigned ClkFreq     = 100_000_000,
    parameter int unsigned SettleTime  = 10,
    parameter int unsigned BounceCount = 3,
    parameter int unsigned MinHold     = 1000,
    parameter int unsigned JitterBits  = 10,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic level_i,
    output logic ready_o,
    output logic sw_o,
    output logic busy_o,
    output logic done_tick_o
);

    localparam int unsigned SettleCycles = 32'((64'(ClkFreq) * 64'(SettleTime)) / 64'd1000);
    localparam int unsigned CntW         = cnt_width(SettleCycles, MinHold + (32'd1 << JitterBits));
    localparam int unsigned ExtraToggles = 2 * BounceCount;
    localparam int unsigned LastBounce   = (ExtraToggles == 0) ? 0 : ExtraToggles - 1;
    localparam int unsigned ToggleW      = (ExtraToggles < 2) ? 1 : $clog2(ExtraToggles);

    if (MinHold < 1) begin : g_bad_min_hold
        $error("switch_bounce_gen: MinHold must be >= 1");
    end
    if (JitterBits > 16) begin : g_bad_jitter_bits
        $error("switch_bounce_gen: JitterBits must be <= 16");
    end
    if (SettleCycles < 1) begin : g_bad_settle
        $error("switch_bounce_gen: SettleCycles must be >= 1");
    end
    if (LfsrSeed == 16'h0000) begin : g_zero_seed
        $info("switch_bounce_gen: zero LfsrSeed is replaced by 16'h0001");
    end

    state_t              state;
    logic [CntW-1:0]     cnt;
    logic [ToggleW-1:0]  toggle_cnt;
    logic [CntW-1:0]     interval_last;
    logic                accept_c;

    assign accept_c = req_i && ready_o;

`ifdef SWITCH_BOUNCE_GEN_JITTER_EN
    localparam logic [15:0] JitterMask = 16'((32'd1 << JitterBits) - 1);

    if (JitterBits < 1) begin : g_bad_jitter_min
        $error("switch_bounce_gen: JitterBits must be >= 1 when jitter is enabled");
    end

    logic [15:0]     lfsr_q;
    logic [CntW-1:0] interval_q;
    logic            toggle_c;

    // Every toggle of sw_o (including the one on accept) consumes one LFSR step
    assign toggle_c = (state == IDLE && accept_c && (level_i != sw_o)) ||
                      (state == BOUNCE && cnt == interval_last);

    lfsr16 #(.Seed(LfsrSeed)) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .step_i  (toggle_c),
        .state_o (lfsr_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            interval_q <= CntW'(MinHold);
        end else if (toggle_c) begin
            interval_q <= CntW'(MinHold) + CntW'(lfsr_q & JitterMask);
        end
    end

    assign interval_last = interval_q - CntW'(1);
`else
    assign interval_last = CntW'(MinHold - 1);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            sw_o        <= 1'b0;
            ready_o     <= 1'b1;
            busy_o      <= 1'b0;
            done_tick_o <= 1'b0;
            cnt         <= '0;
            toggle_cnt  <= '0;
        end else begin
            done_tick_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (level_i != sw_o) begin
                            // First toggle happens on the accept edge itself
                            sw_o       <= level_i;
                            cnt        <= '0;
                            toggle_cnt <= '0;
                            ready_o    <= 1'b0;
                            busy_o     <= 1'b1;
                            state      <= (ExtraToggles == 0) ? SETTLE : BOUNCE;
                        end else begin
                            done_tick_o <= 1'b1;
                        end
                    end
                end
                BOUNCE: begin
                    if (cnt == interval_last) begin
                        sw_o <= ~sw_o;
                        cnt  <= '0;
                        if (toggle_cnt == ToggleW'(LastBounce)) begin
                            state <= SETTLE;
                        end else begin
                            toggle_cnt <= toggle_cnt + ToggleW'(1);
                        end
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == CntW'(SettleCycles - 1)) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        ready_o     <= 1'b1;
                        busy_o      <= 1'b0;
                        done_tick_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Bench for switch_bounce_gen: directed and randomized commands checked cycle by cycle against
// a timeline model (toggle offsets + settle length) built from the command rules.
module tb_switch_bounce_gen;

    localparam int unsigned SettleCycles = 1000;
    localparam int unsigned BounceCount  = 2;
    localparam int unsigned MinHold      = 4;
    localparam int unsigned JitterBits   = 3;
    localparam int unsigned Toggles      = 2 * BounceCount + 1;
    localparam logic [15:0] Seed         = 16'hACE1;

    logic clk_i = 1'b0;
    logic rst_i;
    logic req_i;
    logic level_i;
    logic ready_o;
    logic sw_o;
    logic busy_o;
    logic done_tick_o;

    int   n_pass  = 0;
    int   n_total = 0;
    logic m_sw;
`ifdef SWITCH_BOUNCE_GEN_JITTER_EN
    logic [15:0] m_lfsr;
`endif

    switch_bounce_gen #(
        .ClkFreq     (100_000),
        .SettleTime  (10),
        .BounceCount (BounceCount),
        .MinHold     (MinHold),
        .JitterBits  (JitterBits),
        .LfsrSeed    (Seed)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .level_i     (level_i),
        .ready_o     (ready_o),
        .sw_o        (sw_o),
        .busy_o      (busy_o),
        .done_tick_o (done_tick_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp, input int n);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %b expected %b", tag, n, obs, exp);
    endtask

    // Spacing until the next toggle; with jitter the model LFSR advances once per toggle
    function automatic int unsigned next_interval();
`ifdef SWITCH_BOUNCE_GEN_JITTER_EN
        int unsigned iv;
        iv = MinHold + (int'(m_lfsr) % (2 ** JitterBits));
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else           m_lfsr = m_lfsr >> 1;
        return iv;
`else
        return MinHold;
`endif
    endfunction

    task automatic model_reset();
        m_sw = 1'b0;
`ifdef SWITCH_BOUNCE_GEN_JITTER_EN
        m_lfsr = Seed;
`endif
    endtask

    task automatic idle_checks(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            check("idle_sw_o", sw_o, m_sw, i);
            check("idle_ready_o", ready_o, 1'b1, i);
            check("idle_busy_o", busy_o, 1'b0, i);
            check("idle_done_tick_o", done_tick_o, 1'b0, i);
        end
    endtask

    // Issue one command at a negedge and check every cycle until just past completion.
    // abort_after >= 0 asserts reset one cycle after that toggle index.
    task automatic run_cmd(input logic lvl, input bit hold, input int abort_after);
        int unsigned offs[$];
        int          d;
        int          abort_n;
        logic        start;
        start   = m_sw;
        abort_n = -1;
        if (lvl != m_sw) begin
            offs.push_back(0);
            for (int k = 1; k < int'(Toggles); k++) offs.push_back(offs[k-1] + next_interval());
            void'(next_interval());
            d = int'(offs[offs.size()-1] + SettleCycles);
            if (abort_after >= 0 && abort_after < int'(offs.size())) abort_n = int'(offs[abort_after]) + 1;
        end else begin
            d = 0;
        end
        check("ready_before_req", ready_o, 1'b1, -1);
        req_i   = 1'b1;
        level_i = lvl;
        for (int n = 0; n <= d + 2; n++) begin
            int flips;
            flips = 0;
            @(negedge clk_i);
            foreach (offs[k]) if (int'(offs[k]) <= n) flips++;
            check("sw_o", sw_o, start ^ flips[0], n);
            check("busy_o", busy_o, n < d, n);
            check("ready_o", ready_o, n >= d, n);
            check("done_tick_o", done_tick_o, n == d, n);
            if (n == abort_n) begin
                rst_i = 1'b1;
                #1;
                check("abort_sw_o", sw_o, 1'b0, n);
                check("abort_ready_o", ready_o, 1'b1, n);
                check("abort_busy_o", busy_o, 1'b0, n);
                check("abort_done_tick_o", done_tick_o, 1'b0, n);
                req_i = 1'b0;
                @(negedge clk_i);
                rst_i = 1'b0;
                model_reset();
                idle_checks(20);
                return;
            end
            if (n >= d) begin
                req_i = 1'b0;
            end else if (hold) begin
                req_i   = (n == d - 1) ? 1'b1 : 1'($urandom_range(0, 1));
                level_i = 1'($urandom_range(0, 1));
            end else begin
                req_i = 1'b0;
            end
        end
        m_sw = lvl;
    endtask

    initial begin
        rst_i   = 1'b1;
        req_i   = 1'b0;
        level_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        check("rst_sw_o", sw_o, 1'b0, 0);
        check("rst_ready_o", ready_o, 1'b1, 0);
        check("rst_busy_o", busy_o, 1'b0, 0);
        check("rst_done_tick_o", done_tick_o, 1'b0, 0);
        rst_i = 1'b0;
        idle_checks(30);

        // Same level as current: immediate done, no toggles
        run_cmd(1'b0, 1'b0, -1);
        idle_checks(3);
        // Clean 0 -> 1 command
        run_cmd(1'b1, 1'b0, -1);
        idle_checks(3);
        // 1 -> 0 with requests hammering throughout, including the done edge
        run_cmd(1'b0, 1'b1, -1);
        idle_checks(3);
        // Abort by reset after the third toggle, then a normal command
        run_cmd(1'b1, 1'b0, 2);
        run_cmd(1'b1, 1'b0, -1);
        idle_checks(2);
        // Randomized commands
        for (int i = 0; i < 5; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            idle_checks(int'($urandom_range(1, 4)));
        end
        // Sequence after a fresh reset must repeat the same waveform
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        idle_checks(2);
        run_cmd(1'b1, 1'b0, -1);
        idle_checks(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_bounce_gen.md
Name: switch_bounce_gen

Overview:
- Synthesizable mechanical-switch emulator. It is the driving end of the switch-conditioning path, and its output feeds the debounced input of the design under test.
- Accepts a clean level command through a req/ready handshake.
- Emits a bouncy waveform: a burst of pseudo-random-width glitches, then a stable hold, then a completion tick.
- Used on-FPGA for hardware-in-loop tests of debounced FSMs, and in simulation benches.

Parameters:
- ClkFreq, 100_000_000, clock frequency in Hz.
- SettleTime, 10, stable hold after the last toggle, in ms. SettleCycles = ClkFreq*SettleTime/1000.
- BounceCount, 3, glitch pairs per transition. Total toggles = 2*BounceCount+1.
- MinHold, 1000, minimum cycles between toggles (>=1).
- JitterBits, 10, random extra cycles between toggles, range 0..2^JitterBits-1.
- LfsrSeed, 16'hACE1, LFSR reset value. Must be nonzero.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  1  command request.
- level_i  input  1  target switch level, sampled when req_i && ready_o.
- ready_o  output  1  high only in IDLE; command is accepted on the cycle req_i && ready_o.
- sw_o  output  1  emulated switch signal, registered.
- busy_o  output  1  high in BOUNCE or SETTLE.
- done_tick_o  output  1  one-cycle pulse when a command completes.

Behaviour:
- Clock and reset: one clock (clk_i). Reset rst_i is asynchronous and active-high.
- Reset values: sw_o=0, ready_o=1, busy_o=0, done_tick_o=0, state=IDLE, LFSR=LfsrSeed, counters=0.
- States: IDLE, BOUNCE, SETTLE.
- IDLE, accept with level_i != sw_o:
  - latch target, toggle_cnt=0, interval counter=0, go to BOUNCE.
  - first toggle of sw_o happens on the accept edge, i.e. sw_o changes 1 cycle after the accept cycle.
- IDLE, accept with level_i == sw_o:
  - stay in IDLE, no toggles.
  - done_tick_o=1 on the next cycle.
- BOUNCE:
  - after each toggle, load interval = MinHold + (lfsr[JitterBits-1:0]); the LFSR advances once per toggle.
  - when the interval counter reaches interval-1, toggle sw_o and increment toggle_cnt.
  - once 2*BounceCount+1 toggles are done (sw_o == target), go to SETTLE with counter=0.
- SETTLE:
  - sw_o held.
  - when the counter reaches SettleCycles-1: done_tick_o=1 for one cycle, return to IDLE. ready_o is high in that same done cycle.
- req_i while busy: ignored, not queued. The requester must wait for ready_o.
- Simultaneous done and req: ready_o is 0 during the last SETTLE cycle, so the new request is taken the following cycle.
- BounceCount=0: a single clean toggle, then SETTLE.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - never all-zero. If the seed is zero, the implementation forces 16'h0001.
- Counter width: $clog2(max(SettleCycles, MinHold+2^JitterBits)+1). Counting is unsigned, with no wrap under legal parameters.
- Reset mid-operation: immediate abort. sw_o=0, IDLE, no done_tick_o.
- Elaboration checks: MinHold>=1, JitterBits<=16, SettleCycles>=1.

Optional Feature:
- Macro: SWITCH_BOUNCE_GEN_JITTER_EN.
- Defined: intervals use LFSR jitter as specified above.
- Undefined:
  - no LFSR is instantiated.
  - every interval is exactly MinHold cycles, giving deterministic waveforms for golden-vector checks.
  - LfsrSeed and JitterBits are unused.

Decomposition:
- Package switch_bounce_pkg:
  - state enum (IDLE, BOUNCE, SETTLE).
  - LFSR tap constant 16'hB400.
  - function computing the counter width.
- Sub-module lfsr16:
  - ports clk_i, rst_i, step_i, seed param, state_o.
  - instantiated only under SWITCH_BOUNCE_GEN_JITTER_EN.

Test Plan (ClkFreq=100_000, SettleTime=10 -> SettleCycles=1000, BounceCount=2, MinHold=4, JitterBits=3, macro undefined unless noted):
- Reset release, no req -> sw_o=0, ready_o=1, busy_o=0, done_tick_o=0 held indefinitely.
- req with level_i=1 from sw_o=0 -> 5 toggles spaced exactly 4 cycles apart, final sw_o=1; then 1000 stable cycles; one done_tick_o pulse; ready_o=1.
- req with level_i=0 while sw_o=0 -> no toggle, done_tick_o pulse 1 cycle after accept, state stays IDLE.
- req pulses held throughout BOUNCE and SETTLE -> ignored; exactly one done_tick_o; a second command is accepted only after ready_o returns.
- rst_i asserted mid-BOUNCE after toggle 3 -> sw_o=0 asynchronously, IDLE, no done_tick_o; a subsequent command runs normally.
- Macro defined, LfsrSeed=16'hACE1 -> inter-toggle intervals in 4..11, matching the reference-model LFSR sequence, final level correct, and the sequence repeats identically after reset.
